fetch_buffer: RTL and testbench

Instruction fetch front end that feeds the single-cycle datapath's decode/register-read stage. Holds the program counter, issues sequential word fetches to instruction memory over a valid/ready request channel, collects in-order responses into a small queue and presents each instruction with its PC over a valid/ready output. A redirect input from branch/jump resolution flushes the queue, discards in-flight responses and restarts fetch at the new target.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/fetch_buffer.sv | 100 ++++++++++
 tb/tb_fetch_buffer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-path constants and the queue entry type pairing an instruction with its PC.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] PC_STEP          = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; a push is accepted into a full FIFO only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && (count != '0);
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch front end: PC sequencing, credit-limited memory requests,
// in-order response queue and redirect flush with stale-response discard.
import fetch_pkg::*;

module fetch_buffer #(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int            CW       = $clog2(DEPTH + 1);
    localparam logic [CW:0]   CREDITS  = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] redirect_target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   count;
    logic [CW-1:0]   rsp_dec;
    logic [CW-1:0]   in_flight_after;
    logic [CW:0]     in_use;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic            unused_addr_bits;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    assign redirect_target  = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_addr_bits = ^redirect_pc[1:0];

    // Credits cover both in-flight requests and buffered entries so a response always has a slot.
    assign in_use          = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid  = reset && !redirect && (in_use < CREDITS);
    assign imem_req_addr   = fetch_pc;
    assign req_fire        = imem_req_valid && imem_req_ready;

    assign rsp_dec         = (imem_rsp_valid && (outstanding != '0)) ? CNT_ONE : '0;
    assign in_flight_after = outstanding - rsp_dec;

    assign push       = reset && imem_rsp_valid && !redirect && (discard == '0);
    assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

    assign instr_valid = reset && (count != '0);
    assign pop         = instr_valid && instr_ready;
    assign instr       = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc    : '0;

    // Redirect wins over everything; requests still in flight at that point are marked for discard.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect) begin
            fetch_pc    <= redirect_target;
            rsp_pc      <= redirect_target;
            outstanding <= in_flight_after;
            discard     <= in_flight_after;
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
            outstanding <= outstanding + CW'(req_fire) - rsp_dec;
            if (imem_rsp_valid) begin
                if (discard != '0) discard <= discard - CNT_ONE;
                else               rsp_pc  <= rsp_pc + PC_STEP;
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (count)
    );

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with a latency-configurable memory model and an output scoreboard.
import fetch_pkg::*;

module tb_fetch_buffer;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int lat     = 1;
    int hs_cnt  = 0;
    int req_cnt = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t        pend[$];
    fetch_entry_t exp_q[$];
    logic [31:0]  req_log[$];
    logic [31:0]  out_log[$];

    fetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'hFFFF_FFF8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_1357;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rdr, input logic [31:0] rpc,
                                 input logic rdy, input logic mrdy);
        reset          = rst;
        redirect       = rdr;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        imem_req_ready = mrdy;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitValid(input int budget);
        for (int i = 0; i < budget && !instr_valid; i++) stepCycles(1);
    endtask

    // Memory model and scoreboard; inputs are stable at the falling edge, so this decides the next edge.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            pend.delete();
            exp_q.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else begin
            if (instr_valid && instr_ready) begin
                hs_cnt++;
                out_log.push_back(instr_pc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("[TB] FAIL spurious_instr observed pc %h expected no output", instr_pc);
                end else begin
                    fetch_entry_t e;
                    e = exp_q.pop_front();
                    checkOutput("sb_instr_pc", instr_pc, e.pc);
                    checkOutput("sb_instr", instr, e.instr);
                end
            end
            if (redirect) exp_q.delete();
            if (imem_req_valid && imem_req_ready) begin
                exp_q.push_back('{pc: imem_req_addr, instr: mem_word(imem_req_addr)});
                pend.push_back('{addr: imem_req_addr, due: cyc + lat});
                req_log.push_back(imem_req_addr);
                req_cnt++;
            end
            if (pend.size() > 0 && pend[0].due == cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    end

    initial begin
        int hs0;

        // Reset with memory always ready and latency 1.
        lat = 1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        stepCycles(3);
        checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        checkOutput("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        #1;
        checkOutput("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("first_req_addr", imem_req_addr, 32'hFFFF_FFF8);
        checkOutput("first_instr_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("first_instr", instr, 32'd0);
        checkOutput("first_instr_pc", instr_pc, 32'd0);

        // Streaming: wrapping addresses and one instruction per cycle after warm-up.
        stepCycles(6);
        hs0 = hs_cnt;
        stepCycles(10);
        checkOutput("throughput", hs_cnt - hs0, 32'd10);
        checkOutput("req_addr0", req_log[0], 32'hFFFF_FFF8);
        checkOutput("req_addr1", req_log[1], 32'hFFFF_FFFC);
        checkOutput("req_addr2", req_log[2], 32'h0000_0000);
        checkOutput("out_pc0", out_log[0], 32'hFFFF_FFF8);
        checkOutput("out_pc1", out_log[1], 32'hFFFF_FFFC);
        checkOutput("out_pc2", out_log[2], 32'h0000_0000);

        // Redirect with the consumer stalled: credits cap requests at the queue depth.
        applyStimulus(1'b1, 1'b1, 32'h200, 1'b0, 1'b1);
        #1;
        checkOutput("redir1_no_req", {31'b0, imem_req_valid}, 32'd0);
        stepCycles(1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        req_cnt = 0;
        #1;
        checkOutput("redir1_instr_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("redir1_req_valid", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("redir1_req_addr", imem_req_addr, 32'h200);
        stepCycles(10);
        checkOutput("stall_req_count", req_cnt, 32'd4);
        checkOutput("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        checkOutput("stall_instr_valid", {31'b0, instr_valid}, 32'd1);
        checkOutput("stall_head_pc", instr_pc, 32'h200);
        checkOutput("stall_head_instr", instr, mem_word(32'h200));
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        hs0 = hs_cnt;
        stepCycles(4);
        checkOutput("stall_drain", hs_cnt - hs0, 32'd4);

        // Latency 3, redirect to an unaligned target with three requests in flight.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        stepCycles(6);
        lat = 3;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        stepCycles(3);
        applyStimulus(1'b1, 1'b1, 32'h103, 1'b1, 1'b1);
        #1;
        checkOutput("redir2_no_req", {31'b0, imem_req_valid}, 32'd0);
        stepCycles(1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        #1;
        checkOutput("redir2_req_addr", imem_req_addr, 32'h100);
        checkOutput("redir2_req_valid", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("redir2_instr_valid", {31'b0, instr_valid}, 32'd0);
        waitValid(20);
        checkOutput("redir2_out_valid", {31'b0, instr_valid}, 32'd1);
        checkOutput("redir2_out_pc", instr_pc, 32'h100);
        checkOutput("redir2_out_instr", instr, mem_word(32'h100));

        // Redirect coinciding with a response and an output handshake, latency 1.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        stepCycles(6);
        lat = 1;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        stepCycles(6);
        applyStimulus(1'b1, 1'b1, 32'h300, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("redir3_hs_valid", {31'b0, instr_valid}, 32'd1);
        checkOutput("redir3_rsp_present", {31'b0, imem_rsp_valid}, 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        #1;
        checkOutput("redir3_empty", {31'b0, instr_valid}, 32'd0);
        checkOutput("redir3_req_addr", imem_req_addr, 32'h300);
        waitValid(20);
        checkOutput("redir3_out_pc", instr_pc, 32'h300);

        // Fill the queue, then pulse reset low for one cycle.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        stepCycles(8);
        checkOutput("full_instr_valid", {31'b0, instr_valid}, 32'd1);
        checkOutput("full_req_valid", {31'b0, imem_req_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        checkOutput("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        checkOutput("midrst_instr_valid", {31'b0, instr_valid}, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        #1;
        checkOutput("postrst_instr_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("postrst_instr_pc", instr_pc, 32'd0);
        checkOutput("postrst_req_valid", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("postrst_req_addr", imem_req_addr, 32'hFFFF_FFF8);
        waitValid(20);
        checkOutput("postrst_out_pc", instr_pc, 32'hFFFF_FFF8);
        stepCycles(10);

        // Stop fetching and let everything outstanding drain through the scoreboard.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        stepCycles(8);
        checkOutput("drain_pending", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
